// File: rtl/mem_wait_bridge.sv
`timescale 1ns/1ps
// mem_wait_bridge
//   Bridges the multi-cycle core's one-shot request/ready handshake onto an
//   asynchronous word memory. A read holds mem_read for READ_WAIT cycles so
//   the slow array output has settled before it is captured. A write pulses
//   mem_write for one cycle; the memory commits on the rising edge that ends
//   that cycle. Word-misaligned requests are answered with an error and never
//   reach the memory.
//
// Ports
//   clk            rising-edge clock
//   reset          asynchronous active-low reset
//   cpu_req        request strobe, sampled only while idle
//   cpu_we         1 = write, 0 = read (sampled with cpu_req)
//   cpu_addr       byte address (sampled with cpu_req)
//   cpu_wdata      write data (sampled with cpu_req)
//   cpu_rdata      last captured read data, held until the next read completes
//   cpu_ready      one-cycle completion pulse
//   cpu_err        high with cpu_ready for a misaligned access
//   mem_read       memory read enable
//   mem_write      memory write enable
//   mem_addr       latched address
//   mem_write_data latched write data
//   mem_read_data  asynchronous memory read data
module mem_wait_bridge #(
  parameter int unsigned READ_WAIT = 3,
  parameter int unsigned ADDR_W    = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [ADDR_W-1:0] cpu_wdata,
  output logic [ADDR_W-1:0] cpu_rdata,
  output logic              cpu_ready,
  output logic              cpu_err,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [ADDR_W-1:0] mem_write_data,
  input  logic [ADDR_W-1:0] mem_read_data
);

  localparam int unsigned CNT_W = 4;

  // Reject parameter values the 4-bit wait counter cannot represent.
  if (READ_WAIT < 1 || READ_WAIT > 15) begin : g_bad_read_wait
    $error("mem_wait_bridge: READ_WAIT must be within 1..15");
  end
  if (ADDR_W < 2) begin : g_bad_addr_w
    $error("mem_wait_bridge: ADDR_W must be at least 2");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   wait_cnt;
  logic               we;

  // Access sequencer. Strobes are registered alongside the state so each one
  // is high exactly while the machine sits in the matching state, and the
  // asynchronous reset drops them the instant reset asserts. cpu_err doubles
  // as the error flag: it is set only on a misaligned accept (which goes
  // straight to DONE) and cleared on the exit from DONE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      wait_cnt       <= '0;
      we             <= 1'b0;
      mem_addr       <= '0;
      mem_write_data <= '0;
      cpu_rdata      <= '0;
      cpu_ready      <= 1'b0;
      cpu_err        <= 1'b0;
      mem_read       <= 1'b0;
      mem_write      <= 1'b0;
    end else begin
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      cpu_ready <= 1'b0;
      unique case (state)
        IDLE: begin
          if (cpu_req) begin
            mem_addr       <= cpu_addr;
            mem_write_data <= cpu_wdata;
            we             <= cpu_we;
            if (cpu_addr[1:0] != 2'b00) begin
              state     <= DONE;
              cpu_ready <= 1'b1;
              cpu_err   <= 1'b1;
            end else if (cpu_we) begin
              state     <= WR;
              mem_write <= 1'b1;
            end else begin
              state    <= RD;
              wait_cnt <= CNT_W'(READ_WAIT - 1);
              mem_read <= 1'b1;
            end
          end
        end

        // Keep mem_read up until the counter has run out, then capture.
        RD: begin
          if (wait_cnt != '0) begin
            wait_cnt <= wait_cnt - CNT_W'(1);
            mem_read <= 1'b1;
          end else begin
            if (!we) begin
              cpu_rdata <= mem_read_data;
            end
            state     <= DONE;
            cpu_ready <= 1'b1;
          end
        end

        // Single write cycle; the memory commits on this closing edge.
        WR: begin
          state     <= DONE;
          cpu_ready <= 1'b1;
        end

        DONE: begin
          state   <= IDLE;
          cpu_err <= 1'b0;
        end

        default: begin
          state   <= IDLE;
          cpu_err <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/mem_wait_bridge.md
Name: mem_wait_bridge

Overview:
- Sits between the multi-cycle MIPS core and the asynchronous word memory.
- Converts a one-shot core request (req/ready handshake) into correctly timed memory read/write strobes.
- Holds mem_read asserted for a fixed number of wait cycles so the slow async read data (7 ns access at a 2.5 ns clock) is valid before capture.
- Rejects misaligned word accesses without touching memory.

Parameters:
- READ_WAIT, 3, cycles mem_read is held before read data is captured; legal range 1..15.
- ADDR_W, 32, width of the address and data buses.

Ports:
- clk  input  1  system clock, rising-edge active.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- cpu_req  input  1  core request strobe; sampled only in IDLE.
- cpu_we  input  1  1 = write, 0 = read; sampled with cpu_req.
- cpu_addr  input  ADDR_W  byte address; sampled with cpu_req.
- cpu_wdata  input  ADDR_W  write data; sampled with cpu_req.
- cpu_rdata  output  ADDR_W  registered read data; valid while cpu_ready=1 and held until the next read completes.
- cpu_ready  output  1  one-cycle completion pulse.
- cpu_err  output  1  high together with cpu_ready when the access was misaligned.
- mem_read  output  1  memory read enable.
- mem_write  output  1  memory write enable; memory writes on the rising edge ending the cycle.
- mem_addr  output  ADDR_W  latched address, driven to memory.
- mem_write_data  output  ADDR_W  latched write data.
- mem_read_data  input  ADDR_W  asynchronous memory read data.

Behaviour:
- States: IDLE, RD, WR, DONE.
- mem_read, mem_write, cpu_ready and cpu_err are decoded from registered state/flags only; none depends combinationally on inputs.
- Reset (reset=0, asynchronous):
  - state=IDLE, wait counter=0.
  - Latched addr/wdata/we = 0, so mem_addr=0 and mem_write_data=0.
  - cpu_rdata=0; cpu_ready, cpu_err, mem_read, mem_write = 0.
  - Deassertion is synchronous to the next rising edge as seen by the flops; the first accept can occur on the first edge with reset=1.
- IDLE:
  - All strobes are 0.
  - On an edge with cpu_req=1, latch cpu_addr, cpu_we and cpu_wdata.
  - If cpu_addr[1:0]!=0: set err flag, go to DONE; no memory strobe is ever asserted.
  - Else if cpu_we=1: go to WR.
  - Else: go to RD with counter=READ_WAIT-1.
- RD:
  - mem_read=1.
  - Each edge with counter!=0 decrements the counter.
  - On the edge with counter==0: cpu_rdata <= mem_read_data, go to DONE.
  - mem_read is therefore high for exactly READ_WAIT consecutive cycles.
- WR: mem_write=1 for exactly one cycle, then DONE. cpu_rdata is unchanged.
- DONE:
  - cpu_ready=1, plus cpu_err=err flag, for exactly one cycle; then IDLE.
  - err flag clears on the exit to IDLE.
- Latency from the accepting edge to cpu_ready high:
  - read: READ_WAIT+1 cycles (READ_WAIT cycles in RD, then DONE).
  - write: 2 cycles (WR, then DONE).
  - misaligned: 1 cycle (DONE).
- cpu_req in RD, WR or DONE is ignored; no queueing.
  - A request held high through DONE is accepted on the first IDLE edge, giving one bubble cycle between back-to-back accesses.
- mem_read and mem_write are never high in the same cycle.
- mem_addr and mem_write_data are stable for the entire access.
- Reset mid-access: strobes drop immediately.
  - A WR aborted before its closing edge produces no memory write.
  - An aborted RD produces no cpu_ready pulse.
  - cpu_rdata reads 0 after reset.
- Counter width: 4 bits. Behaviour for READ_WAIT=0 or >15 is unsupported; elaboration fails via a generate-time check.

Test Plan (2.5 ns period, READ_WAIT=3, memory 7 ns read delay):
- Reset release, then read addr 0x000000C8 holding 0x1234ABCD -> mem_read high for exactly 3 cycles with mem_addr=0xC8; cpu_ready pulses 4 cycles after accept; cpu_rdata=0x1234ABCD; cpu_err=0.
- Write addr 0xCC, data 0xDEADBEEF, then read 0xCC -> mem_write high for 1 cycle; ready 2 cycles after accept; the following read returns 0xDEADBEEF.
- Read of misaligned addr 0xC9 -> cpu_ready and cpu_err high 1 cycle after accept; mem_read and mem_write stay 0; cpu_rdata unchanged.
- cpu_req held high for 3 back-to-back reads (0xC8, 0xCC, 0xD0) -> each completes in 4 cycles, with one IDLE cycle between each ready pulse and the next mem_read rise; 15 cycles total.
- Assert reset during the WR cycle of a write to 0xD4 (old value 0x0) -> mem_write drops at once, memory at 0xD4 stays 0x0, no cpu_ready pulse; after release a read of 0xD4 returns 0x0.
- Assert reset in the 2nd RD cycle -> mem_read=0 immediately, cpu_rdata=0, no ready pulse; the next read completes normally.
